// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: memOp/memSize codes and FSM states.
package mem_stage_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  // Size code 11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF)
      mis = addr_lo[0];
    else if (size == SZ_WORD || size == 2'b11)
      mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/strobe generation and load extract with sign/zero extension.
module lsu_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_din,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  // Misaligned offsets are truncated to natural alignment by only looking at the relevant address bits.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = st_din;
    case (st_size)
      SZ_BYTE: begin
        st_wstrb = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_din[7:0]}};
      end
      SZ_HALF: begin
        st_wstrb = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_din[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = st_din;
      end
    endcase
  end

  always_comb begin
    byte_v = ld_word[7:0];
    case (ld_addr_lo)
      2'd0: byte_v = ld_word[7:0];
      2'd1: byte_v = ld_word[15:8];
      2'd2: byte_v = ld_word[23:16];
      default: byte_v = ld_word[31:24];
    endcase
    half_v = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    sext   = ~ld_unsigned;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{sext & byte_v[7]}}, byte_v};
      SZ_HALF: ld_data = {{16{sext & half_v[15]}}, half_v};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: ALU passthrough in 1 cycle, stores >=2, loads >=3; holds execute while REQ/RESP.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of truncating them.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int RESP_TIMEOUT = 0,
  parameter int TIMEOUT_W    = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        inValid,
  input  logic [31:0] aluToMem,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic        memUnsigned,
  input  logic [31:0] memDin,
  input  logic [4:0]  rdIn,
  input  logic        regWriteIn,
  output logic        hold,
  output logic        dReqValid,
  input  logic        dReqReady,
  output logic        dReqWrite,
  output logic [31:0] dReqAddr,
  output logic [3:0]  dReqWstrb,
  output logic [31:0] dReqWdata,
  input  logic        dRespValid,
  input  logic [31:0] dRespData,
  output logic        wbValid,
  output logic        wbWe,
  output logic [4:0]  wbRd,
  output logic [31:0] wbData,
  output logic        busErr
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalignTrap
`endif
);

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]            addr_q;
  logic [1:0]             size_q;
  logic                   uns_q, we_q, write_q;
  logic [4:0]             rd_q;
  logic [3:0]             wstrb_q, st_wstrb;
  logic [31:0]            wdata_q, st_wdata, ld_data;
  logic                   capture, is_mem;
  logic                   wb_vld_d, wb_we_d, bus_err_d, trap_d;
  logic [4:0]             wb_rd_d;
  logic [31:0]            wb_dat_d;

  lsu_lane_align u_align (
    .st_addr_lo  (aluToMem[1:0]),
    .st_size     (memSize),
    .st_din      (memDin),
    .st_wstrb    (st_wstrb),
    .st_wdata    (st_wdata),
    .ld_addr_lo  (addr_q[1:0]),
    .ld_size     (size_q),
    .ld_unsigned (uns_q),
    .ld_word     (dRespData),
    .ld_data     (ld_data)
  );

  assign is_mem    = (memOp == MEM_LOAD) || (memOp == MEM_STORE);
  assign hold      = (state_q != IDLE);
  assign dReqValid = (state_q == REQ);
  assign dReqWrite = write_q;
  assign dReqAddr  = {addr_q[31:2], 2'b00};
  assign dReqWstrb = wstrb_q;
  assign dReqWdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    wb_vld_d  = 1'b0;
    wb_we_d   = 1'b0;
    wb_rd_d   = wbRd;
    wb_dat_d  = wbData;
    bus_err_d = 1'b0;
    trap_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (inValid && is_mem) begin
`ifdef MEM_MISALIGN_TRAP_EN
          if (is_misaligned(memSize, aluToMem[1:0])) begin
            wb_vld_d = 1'b1;
            wb_rd_d  = rdIn;
            wb_dat_d = aluToMem;
            trap_d   = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = REQ;
          end
`else
          capture = 1'b1;
          state_d = REQ;
`endif
        end else begin
          wb_vld_d = inValid;
          wb_we_d  = regWriteIn;
          wb_rd_d  = rdIn;
          wb_dat_d = aluToMem;
        end
      end
      REQ: begin
        if (dReqReady) begin
          if (write_q) begin
            wb_vld_d = 1'b1;
            wb_rd_d  = rd_q;
            state_d  = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        // A response in the final timeout cycle still wins over the abort.
        if (dRespValid) begin
          wb_vld_d = 1'b1;
          wb_we_d  = we_q;
          wb_rd_d  = rd_q;
          wb_dat_d = ld_data;
          state_d  = IDLE;
        end else if (RESP_TIMEOUT != 0 &&
                     (cnt_q + TIMEOUT_W'(1)) == TIMEOUT_W'(RESP_TIMEOUT)) begin
          wb_vld_d  = 1'b1;
          wb_rd_d   = rd_q;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      write_q <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      wbValid <= 1'b0;
      wbWe    <= 1'b0;
      wbRd    <= '0;
      wbData  <= '0;
      busErr  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalignTrap <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= aluToMem;
        size_q  <= memSize;
        uns_q   <= memUnsigned;
        rd_q    <= rdIn;
        we_q    <= regWriteIn;
        write_q <= (memOp == MEM_STORE);
        wstrb_q <= st_wstrb;
        wdata_q <= st_wdata;
      end
      wbValid <= wb_vld_d;
      wbWe    <= wb_we_d;
      wbRd    <= wb_rd_d;
      wbData  <= wb_dat_d;
      busErr  <= bus_err_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalignTrap <= trap_d;
`endif
    end
  end

`ifndef MEM_MISALIGN_TRAP_EN
  logic unused_trap;
  assign unused_trap = trap_d;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table of loads/stores plus hand sequences for corner cases.
module tb_mem_access_stage;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic [31:0] aluToMem;
  logic [1:0]  memOp;
  logic [1:0]  memSize;
  logic        memUnsigned;
  logic [31:0] memDin;
  logic [4:0]  rdIn;
  logic        regWriteIn;
  logic        hold;
  logic        dReqValid;
  logic        dReqReady;
  logic        dReqWrite;
  logic [31:0] dReqAddr;
  logic [3:0]  dReqWstrb;
  logic [31:0] dReqWdata;
  logic        dRespValid;
  logic [31:0] dRespData;
  logic        wbValid;
  logic        wbWe;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic        busErr;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalignTrap;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.RESP_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .inValid     (inValid),
    .aluToMem    (aluToMem),
    .memOp       (memOp),
    .memSize     (memSize),
    .memUnsigned (memUnsigned),
    .memDin      (memDin),
    .rdIn        (rdIn),
    .regWriteIn  (regWriteIn),
    .hold        (hold),
    .dReqValid   (dReqValid),
    .dReqReady   (dReqReady),
    .dReqWrite   (dReqWrite),
    .dReqAddr    (dReqAddr),
    .dReqWstrb   (dReqWstrb),
    .dReqWdata   (dReqWdata),
    .dRespValid  (dRespValid),
    .dRespData   (dRespData),
    .wbValid     (wbValid),
    .wbWe        (wbWe),
    .wbRd        (wbRd),
    .wbData      (wbData),
    .busErr      (busErr)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalignTrap(misalignTrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] resp;
    logic [3:0]  strb;
    logic [31:0] wdat;
    logic [31:0] wb;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    inValid     = 1'b0;
    memOp       = 2'b00;
    memSize     = 2'b00;
    memUnsigned = 1'b0;
    aluToMem    = 32'h0;
    memDin      = 32'h0;
    rdIn        = 5'd0;
    regWriteIn  = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    inValid     = 1'b1;
    memOp       = v.op;
    memSize     = v.sz;
    memUnsigned = v.uns;
    aluToMem    = v.addr;
    memDin      = v.din;
    rdIn        = 5'd7;
    regWriteIn  = 1'b1;
  endtask

  // Full transaction with ready on the first REQ cycle and response on the first RESP cycle.
  task automatic run_op(input vec_t v, input string nm);
    logic is_st;
    is_st = (v.op == 2'b10);
    issue(v);
    tick;
    chk({nm, " req hold"}, hold, 1'b1);
    chk({nm, " req valid"}, dReqValid, 1'b1);
    chk({nm, " req addr"}, dReqAddr, {v.addr[31:2], 2'b00});
    chk({nm, " req write"}, dReqWrite, is_st);
    chk({nm, " wb quiet"}, wbValid, 1'b0);
    if (is_st) begin
      chk({nm, " wstrb"}, dReqWstrb, v.strb);
      chk({nm, " wdata"}, dReqWdata, v.wdat);
    end
    idle_inputs();
    dReqReady = 1'b1;
    tick;
    dReqReady = 1'b0;
    if (!is_st) begin
      chk({nm, " resp hold"}, hold, 1'b1);
      chk({nm, " resp reqvalid"}, dReqValid, 1'b0);
      dRespValid = 1'b1;
      dRespData  = v.resp;
      tick;
      dRespValid = 1'b0;
      chk({nm, " wbData"}, wbData, v.wb);
      chk({nm, " wbRd"}, wbRd, 5'd7);
    end
    chk({nm, " wbValid"}, wbValid, 1'b1);
    chk({nm, " wbWe"}, wbWe, !is_st);
    chk({nm, " busErr"}, busErr, 1'b0);
    chk({nm, " done hold"}, hold, 1'b0);
    tick;
    chk({nm, " wb pulse"}, wbValid, 1'b0);
  endtask

  vec_t vecs[11];
  vec_t v;

  initial begin
    // op, sz, uns, addr, din, resp, strb, wdat, wb
    vecs[0]  = '{2'b01, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 4'h0, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{2'b01, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 4'h0, 32'h0, 32'h0000_BEEF};
    vecs[2]  = '{2'b01, 2'b01, 1'b0, 32'h0000_2000, 32'h0, 32'h0000_8001, 4'h0, 32'h0, 32'hFFFF_8001};
    vecs[3]  = '{2'b01, 2'b00, 1'b1, 32'h0000_1001, 32'h0, 32'h1234_A5C3, 4'h0, 32'h0, 32'h0000_00A5};
    vecs[4]  = '{2'b01, 2'b10, 1'b1, 32'h0000_3004, 32'h0, 32'hDEAD_BEEF, 4'h0, 32'h0, 32'hDEAD_BEEF};
    vecs[5]  = '{2'b01, 2'b00, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_007F, 4'h0, 32'h0, 32'h0000_007F};
    vecs[6]  = '{2'b01, 2'b11, 1'b0, 32'h0000_6008, 32'h0, 32'h8765_4321, 4'h0, 32'h0, 32'h8765_4321};
    vecs[7]  = '{2'b10, 2'b00, 1'b0, 32'h0000_3001, 32'h55, 32'h0, 4'b0010, 32'h5555_5555, 32'h0};
    vecs[8]  = '{2'b10, 2'b01, 1'b0, 32'h0000_3002, 32'hCAFE_BEEF, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[9]  = '{2'b10, 2'b10, 1'b0, 32'h0000_3000, 32'h1234_5678, 32'h0, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[10] = '{2'b10, 2'b00, 1'b0, 32'h0000_3003, 32'h0000_00AB, 32'h0, 4'b1000, 32'hABAB_ABAB, 32'h0};

    idle_inputs();
    dReqReady  = 1'b0;
    dRespValid = 1'b0;
    dRespData  = 32'h0;
    rstN       = 1'b0;
    tick;
    tick;
    chk("reset hold", hold, 1'b0);
    chk("reset dReqValid", dReqValid, 1'b0);
    chk("reset dReqAddr", dReqAddr, 32'h0);
    chk("reset wbValid", wbValid, 1'b0);
    chk("reset wbData", wbData, 32'h0);
    chk("reset busErr", busErr, 1'b0);
    rstN = 1'b1;
    tick;

    // ALU passthrough, op 11 treated as none, and a bubble carrying a load opcode.
    inValid = 1'b1; memOp = 2'b00; aluToMem = 32'h0000_1234; rdIn = 5'd5; regWriteIn = 1'b1;
    tick;
    chk("pass wbValid", wbValid, 1'b1);
    chk("pass wbWe", wbWe, 1'b1);
    chk("pass wbRd", wbRd, 5'd5);
    chk("pass wbData", wbData, 32'h0000_1234);
    chk("pass hold", hold, 1'b0);
    memOp = 2'b11; aluToMem = 32'hCAFE_F00D; rdIn = 5'd31; regWriteIn = 1'b0;
    tick;
    chk("op11 wbValid", wbValid, 1'b1);
    chk("op11 wbWe", wbWe, 1'b0);
    chk("op11 wbData", wbData, 32'hCAFE_F00D);
    chk("op11 dReqValid", dReqValid, 1'b0);
    inValid = 1'b0; memOp = 2'b01;
    dRespValid = 1'b1; dRespData = 32'hFFFF_FFFF;
    tick;
    dRespValid = 1'b0;
    chk("bubble wbValid", wbValid, 1'b0);
    chk("bubble hold", hold, 1'b0);
    chk("bubble dReqValid", dReqValid, 1'b0);
    idle_inputs();
    tick;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Store held off by three cycles of backpressure.
    v = vecs[7];
    issue(v);
    tick;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp hold c%0d", i), hold, 1'b1);
      chk($sformatf("bp valid c%0d", i), dReqValid, 1'b1);
      chk($sformatf("bp wstrb c%0d", i), dReqWstrb, 4'b0010);
      chk($sformatf("bp wdata c%0d", i), dReqWdata, 32'h5555_5555);
      chk($sformatf("bp addr c%0d", i), dReqAddr, 32'h0000_3000);
      dReqReady = (i == 3);
      tick;
    end
    dReqReady = 1'b0;
    chk("bp wbValid", wbValid, 1'b1);
    chk("bp wbWe", wbWe, 1'b0);
    chk("bp hold", hold, 1'b0);
    tick;

    // Load response never arrives: abort after four RESP cycles, late response ignored.
    v = vecs[4];
    issue(v);
    tick;
    idle_inputs();
    dReqReady = 1'b1;
    tick;
    dReqReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to hold c%0d", i), hold, 1'b1);
      chk($sformatf("to wbValid c%0d", i), wbValid, 1'b0);
      chk($sformatf("to busErr c%0d", i), busErr, 1'b0);
      tick;
    end
    chk("to wbValid", wbValid, 1'b1);
    chk("to busErr", busErr, 1'b1);
    chk("to wbWe", wbWe, 1'b0);
    chk("to hold", hold, 1'b0);
    dRespValid = 1'b1; dRespData = 32'h1111_1111;
    tick;
    dRespValid = 1'b0;
    chk("late wbValid", wbValid, 1'b0);
    chk("late busErr", busErr, 1'b0);
    chk("late hold", hold, 1'b0);

    // Reset while waiting for a load response.
    v = vecs[0];
    issue(v);
    tick;
    idle_inputs();
    dReqReady = 1'b1;
    tick;
    dReqReady = 1'b0;
    chk("rst pre hold", hold, 1'b1);
    rstN = 1'b0;
    tick;
    chk("rst dReqValid", dReqValid, 1'b0);
    chk("rst hold", hold, 1'b0);
    chk("rst wbValid", wbValid, 1'b0);
    rstN = 1'b1;
    dRespValid = 1'b1; dRespData = 32'h2222_2222;
    tick;
    dRespValid = 1'b0;
    chk("rst stray resp wbValid", wbValid, 1'b0);
    run_op(vecs[1], "post-reset");

`ifdef MEM_MISALIGN_TRAP_EN
    v = '{2'b01, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
    issue(v);
    tick;
    idle_inputs();
    chk("trap dReqValid", dReqValid, 1'b0);
    chk("trap hold", hold, 1'b0);
    chk("trap wbValid", wbValid, 1'b1);
    chk("trap wbWe", wbWe, 1'b0);
    chk("trap flag", misalignTrap, 1'b1);
    chk("trap wbData", wbData, 32'h0000_4002);
    tick;
    chk("trap pulse", misalignTrap, 1'b0);
    chk("trap wb pulse", wbValid, 1'b0);
`else
    // Misaligned accesses truncate to natural alignment.
    run_op('{2'b01, 2'b10, 1'b0, 32'h0000_4002, 32'h0, 32'h1122_3344, 4'h0, 32'h0, 32'h1122_3344}, "mis lw");
    run_op('{2'b10, 2'b01, 1'b0, 32'h0000_3003, 32'h0000_1234, 32'h0, 4'b1100, 32'h1234_1234, 32'h0}, "mis sh");
    run_op('{2'b01, 2'b01, 1'b0, 32'h0000_5001, 32'h0, 32'h7777_C001, 4'h0, 32'h0, 32'hFFFF_C001}, "mis lh");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of execute; consumes its registered outputs: ALU result/address, memOp, memSize, store data.
- Runs a valid/ready request and response handshake with the data memory.
- Aligns store data to byte lanes and extracts/sign-extends load data.
- Produces registered writeback results; asserts hold to freeze execute while a memory access is in flight.

Parameters:
- RESP_TIMEOUT, 0, cycles to wait for a load response before abort; 0 = wait forever
- TIMEOUT_W, 8, width of timeout counter; RESP_TIMEOUT < 2**TIMEOUT_W

Ports:
- clk  in  1  clock, all state on rising edge
- rstN  in  1  synchronous active-low reset
- inValid  in  1  execute outputs hold a real instruction (0 = bubble/flush)
- aluToMem  in  32  ALU result / effective address
- memOp  in  2  00 none, 01 load, 10 store, 11 treated as none
- memSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- memUnsigned  in  1  zero-extend loads (LBU/LHU)
- memDin  in  32  store data, low bits significant
- rdIn  in  5  destination register
- regWriteIn  in  1  instruction writes rd
- hold  out  1  freeze execute stage
- dReqValid  out  1  memory request valid
- dReqReady  in  1  memory accepts request
- dReqWrite  out  1  1 store, 0 load
- dReqAddr  out  32  word-aligned address ({aluToMem[31:2],2'b00})
- dReqWstrb  out  4  byte-lane write enables
- dReqWdata  out  32  lane-aligned store data
- dRespValid  in  1  load data valid
- dRespData  in  32  load word
- wbValid  out  1  writeback slot valid
- wbWe  out  1  register write enable
- wbRd  out  5  destination register
- wbData  out  32  writeback value
- busErr  out  1  load timed out (pulse with wbValid)

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Applies even mid-transaction. Responses arriving in IDLE are ignored.
- FSM states: IDLE, REQ, RESP.
- hold = (state != IDLE), combinational from state only.
- IDLE, inValid=0 or memOp none/11:
  - next cycle wbValid = inValid, wbWe = regWriteIn, wbRd = rdIn, wbData = aluToMem.
  - Latency 1; stays IDLE.
- IDLE, inValid=1 and memOp load/store:
  - Capture address low bits, size, unsigned flag, rd, regWriteIn, aligned wdata/wstrb.
  - Go to REQ; wbValid = 0 next cycle.
- REQ: dReqValid = 1 with stable address, write, wstrb and wdata until dReqReady sampled high.
  - Store accepted: next cycle wbValid = 1, wbWe = 0, state IDLE.
  - Load accepted: go to RESP; clear timeout counter.
- RESP: wait for dRespValid.
  - On dRespValid: wbValid = 1, wbWe = captured regWrite, wbData = extracted value, state IDLE.
  - If RESP_TIMEOUT != 0 and counter reaches RESP_TIMEOUT: wbValid = 1, wbWe = 0, busErr = 1, state IDLE.
- Minimum latency: store 2 cycles (ready in same cycle as REQ); load 3 cycles.
- wbValid, busErr: one-cycle pulses per instruction.
- Store lanes:
  - byte: wstrb = 1 << a[1:0]; wdata = {4{memDin[7:0]}}.
  - half: wstrb = a[1] ? 1100 : 0011; wdata = {2{memDin[15:0]}}.
  - word: wstrb = 1111; wdata = memDin.
- Load extract:
  - byte from lane a[1:0]; half from a[1] ? [31:16] : [15:0]; word as-is.
  - Sign-extend unless memUnsigned; memUnsigned ignored for word.
- dRespValid and dReqReady are ignored outside RESP and REQ respectively.
- Misaligned accesses (half with a[0]=1; word with a[1:0]!=0) without the macro: low bits truncated to natural alignment (a[0] ignored for half, a[1:0] for word); access proceeds.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN. Adds output misalignTrap (1 bit).
- With it: a misaligned load/store in IDLE issues no request and stays IDLE. Next cycle: wbValid = 1, wbWe = 0, misalignTrap = 1 (one-cycle pulse), wbData = faulting address. hold never asserts.
- Without it: truncation behaviour above; port absent.

Decomposition:
- Package mem_stage_pkg:
  - memOp encodings: MEM_NONE, MEM_LOAD, MEM_STORE.
  - memSize encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum: IDLE, REQ, RESP.
- One sub-module lsu_lane_align: purely combinational store lane/strobe generation and load extract/sign-extend; FSM and registers stay in mem_access_stage.

Test Plan:
- ALU passthrough: memOp=00, aluToMem=0x0000_1234, rdIn=5, regWriteIn=1 -> next cycle wbValid=1, wbWe=1, wbRd=5, wbData=0x0000_1234, hold=0.
- LB sign-extend: addr 0x1003, dReqReady same cycle, dRespData=0x80FF_0000 one cycle later -> dReqAddr=0x1000, wbData=0xFFFF_FF80, hold high for 2 cycles.
- LHU: addr 0x2002, memUnsigned=1, dRespData=0xBEEF_1234 -> wbData=0x0000_BEEF.
- SB backpressure: addr 0x3001, memDin=0x55, dReqReady low 3 cycles -> dReqWstrb=0010 and dReqWdata=0x5555_5555 stable throughout; hold high 4 cycles; then wbValid=1, wbWe=0.
- Timeout: RESP_TIMEOUT=4, load with no dRespValid -> after 4 RESP cycles busErr=1, wbWe=0, state IDLE; a late dRespValid is ignored.
- Reset mid-load: rstN=0 while in RESP -> next cycle dReqValid=0, hold=0, wbValid=0.
- With MEM_MISALIGN_TRAP_EN: LW at 0x4002 -> no dReqValid, misalignTrap=1, wbData=0x4002.
